// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the EX-stage bypass producer:
//               datapath width, write-back source encodings and the
//               hazard FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // Write-back source select (RUDataWrSrc). 2'b11 is unused and behaves
  // as WB_ALU wherever it is decoded.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Hazard FSM states.
  //   RUN  : normal flow, load-use and memory-wait detection active
  //   BUB  : the load-use bubble is in EX, the load is in MEM
  //   WAIT : data memory has not completed, whole pipe is held
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUB  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline register with load enable and synchronous
//               clear. Clearing turns the stage into a bubble because every
//               payload field (including write enables) is forced to zero.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset (clears the stage)
//               clr  - synchronous clear, same effect as rst, for bubbles
//               en   - load enable; when low the stage keeps its contents
//               d    - next-stage payload
//               q    - registered payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over enable so a held stage can still be flushed.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_stage_reg
`default_nettype wire

// File: rtl/fwd_source_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe
// Description : Producer side of the EX-stage bypass network. Holds the
//               EX/MEM and MEM/WB pipeline registers, publishes destination
//               tags, write enables and bypass data for the forwarding
//               selector, and resolves the two hazards bypassing cannot hide:
//               the load-use bubble and the data-memory wait hold.
// Ports       : clk, rst                  - clock / sync active-high reset
//               ex_valid, rd_ex, RUWrex,
//               DMRdex, RUDataWrSrcex,
//               alu_ex, pc4_ex            - EX-stage instruction
//               rs1_id, rs2_id,
//               rs1_use_id, rs2_use_id    - ID-stage source operands
//               dm_rdata, dm_ready        - data memory response for MEM
//               rd_mem, RUWrme,
//               fwd_mem_data              - MEM bypass source
//               rd_wb, RUWrwb,
//               fwd_wb_data               - WB bypass / register-file write
//               stall_fd, bubble_ex       - load-use stall controls
//               hold_all                  - memory-wait freeze
//               stall_cnt                 - saturating stall/hold counter
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_source_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  // EX stage
  input  logic            ex_valid,
  input  logic [4:0]      rd_ex,
  input  logic            RUWrex,
  input  logic            DMRdex,
  input  logic [1:0]      RUDataWrSrcex,
  input  logic [XLEN-1:0] alu_ex,
  input  logic [XLEN-1:0] pc4_ex,
  // ID stage operands
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  input  logic            rs1_use_id,
  input  logic            rs2_use_id,
  // data memory
  input  logic [XLEN-1:0] dm_rdata,
  input  logic            dm_ready,
  // bypass sources
  output logic [4:0]      rd_mem,
  output logic [4:0]      rd_wb,
  output logic            RUWrme,
  output logic            RUWrwb,
  output logic [XLEN-1:0] fwd_mem_data,
  output logic [XLEN-1:0] fwd_wb_data,
  // hazard controls
  output logic            stall_fd,
  output logic            bubble_ex,
  output logic            hold_all,
  output logic [CNTW-1:0] stall_cnt
);

  // EX/MEM payload: {wr, rd[4:0], dmrd, src[1:0], alu, pc4}
  localparam int EXM_W = 9 + 2 * XLEN;
  // MEM/WB payload: {wr, rd[4:0], data}
  localparam int MWB_W = 6 + XLEN;

  logic [EXM_W-1:0] exm_d;
  logic [EXM_W-1:0] exm_q;
  logic [MWB_W-1:0] mwb_d;
  logic [MWB_W-1:0] mwb_q;

  logic             ex_wr;
  logic             dmrd_me;
  logic [1:0]       src_me;
  logic [XLEN-1:0]  alu_me;
  logic [XLEN-1:0]  pc4_me;
  logic [XLEN-1:0]  wb_sel_data;

  logic             load_use;
  logic             mem_wait;

  state_t           state_q;
  state_t           state_d;

  // --------------------------------------------------------------------------
  // EX/MEM stage
  // --------------------------------------------------------------------------
  // The tag is zeroed together with the enable so the consumer only needs an
  // rd != 0 compare. The load flag is qualified with ex_valid so a bubble
  // carrying stale decode bits can never trigger a memory wait.
  assign ex_wr = ex_valid & RUWrex & (rd_ex != 5'd0);

  assign exm_d = {ex_wr,
                  (ex_wr ? rd_ex : 5'd0),
                  ex_valid & DMRdex,
                  RUDataWrSrcex,
                  alu_ex,
                  pc4_ex};

  // Frozen while the MEM-stage load is outstanding; the instruction in EX
  // is held upstream and re-presented on the release edge.
  pipe_stage_reg #(
    .W (EXM_W)
  ) u_ex_mem (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (~hold_all),
    .d   (exm_d),
    .q   (exm_q)
  );

  assign {RUWrme, rd_mem, dmrd_me, src_me, alu_me, pc4_me} = exm_q;

  assign fwd_mem_data = (src_me == WB_PC4) ? pc4_me : alu_me;

  // --------------------------------------------------------------------------
  // MEM/WB stage
  // --------------------------------------------------------------------------
  always_comb begin
    wb_sel_data = alu_me;
    case (src_me)
      WB_DM:   wb_sel_data = dm_rdata;
      WB_PC4:  wb_sel_data = pc4_me;
      default: wb_sel_data = alu_me;
    endcase
  end

  assign mwb_d = {RUWrme, rd_mem, wb_sel_data};

  // During a hold the stage is loaded with a bubble: the instruction still
  // sitting in MEM must not be written twice, and WB must not keep
  // advertising an older result as bypassable.
  pipe_stage_reg #(
    .W (MWB_W)
  ) u_mem_wb (
    .clk (clk),
    .rst (rst),
    .clr (hold_all),
    .en  (1'b1),
    .d   (mwb_d),
    .q   (mwb_q)
  );

  assign {RUWrwb, rd_wb, fwd_wb_data} = mwb_q;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign load_use = ex_valid & DMRdex & (rd_ex != 5'd0) &
                    ((rs1_use_id & (rs1_id == rd_ex)) |
                     (rs2_use_id & (rs2_id == rd_ex)));

  assign mem_wait = dmrd_me & ~dm_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The memory hold always wins; a load-use hazard that coincides with it is
  // picked up on the release cycle, when the same EX/ID pair is still
  // presented. In BUB the EX slot is the bubble just inserted, so no new
  // hazard can be raised there. Controls are forced low during reset.
  always_comb begin
    state_d   = state_q;
    stall_fd  = 1'b0;
    bubble_ex = 1'b0;
    hold_all  = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            hold_all = 1'b1;
            state_d  = WAIT;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = BUB;
          end
        end
        BUB: begin
          if (mem_wait) begin
            hold_all = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d  = RUN;
          end
        end
        WAIT: begin
          if (mem_wait) begin
            hold_all = 1'b1;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = BUB;
          end else begin
            state_d   = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stall/hold counter, saturating at all-ones
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall_fd || hold_all) && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule : fwd_source_pipe
`default_nettype wire

// File: tb/tb_fwd_source_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_source_pipe
// Description : Self-checking bench for fwd_source_pipe. Directed scenarios
//               followed by randomized traffic, all compared against a
//               slot-level behavioural model of the MEM and WB stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_source_pipe;

  localparam int XL = 32;
  localparam int CW = 4;   // narrow counter so saturation is reached

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic [4:0]    rd_ex = 5'd0;
  logic          RUWrex = 1'b0;
  logic          DMRdex = 1'b0;
  logic [1:0]    RUDataWrSrcex = 2'b00;
  logic [XL-1:0] alu_ex = '0;
  logic [XL-1:0] pc4_ex = '0;
  logic [4:0]    rs1_id = 5'd0;
  logic [4:0]    rs2_id = 5'd0;
  logic          rs1_use_id = 1'b0;
  logic          rs2_use_id = 1'b0;
  logic [XL-1:0] dm_rdata = '0;
  logic          dm_ready = 1'b1;

  logic [4:0]    rd_mem;
  logic [4:0]    rd_wb;
  logic          RUWrme;
  logic          RUWrwb;
  logic [XL-1:0] fwd_mem_data;
  logic [XL-1:0] fwd_wb_data;
  logic          stall_fd;
  logic          bubble_ex;
  logic          hold_all;
  logic [CW-1:0] stall_cnt;

  fwd_source_pipe #(
    .XLEN (XL),
    .CNTW (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .rd_ex         (rd_ex),
    .RUWrex        (RUWrex),
    .DMRdex        (DMRdex),
    .RUDataWrSrcex (RUDataWrSrcex),
    .alu_ex        (alu_ex),
    .pc4_ex        (pc4_ex),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rs1_use_id    (rs1_use_id),
    .rs2_use_id    (rs2_use_id),
    .dm_rdata      (dm_rdata),
    .dm_ready      (dm_ready),
    .rd_mem        (rd_mem),
    .rd_wb         (rd_wb),
    .RUWrme        (RUWrme),
    .RUWrwb        (RUWrwb),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_data   (fwd_wb_data),
    .stall_fd      (stall_fd),
    .bubble_ex     (bubble_ex),
    .hold_all      (hold_all),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [XL-1:0] got,
                       input logic [XL-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one record per occupied stage slot
  // --------------------------------------------------------------------------
  bit          m_mem_wr;
  bit [4:0]    m_mem_rd;
  bit          m_mem_ld;
  bit [1:0]    m_mem_src;
  bit [XL-1:0] m_mem_alu;
  bit [XL-1:0] m_mem_pc4;
  bit          m_wb_wr;
  bit [4:0]    m_wb_rd;
  bit [XL-1:0] m_wb_data;
  int          m_cnt;
  bit          m_prev_det;   // previous cycle raised a load-use bubble

  function automatic bit exp_hold();
    return !rst && m_mem_ld && !dm_ready;
  endfunction

  function automatic bit exp_stall();
    bit dep;
    dep = (rs1_use_id && (rs1_id == rd_ex)) || (rs2_use_id && (rs2_id == rd_ex));
    return !rst && !exp_hold() && !m_prev_det && ex_valid && DMRdex &&
           (rd_ex != 5'd0) && dep;
  endfunction

  task automatic model_update();
    bit h;
    bit s;
    h = exp_hold();
    s = exp_stall();
    if (rst) begin
      m_mem_wr = 0; m_mem_rd = 0; m_mem_ld = 0; m_mem_src = 0;
      m_mem_alu = 0; m_mem_pc4 = 0;
      m_wb_wr = 0; m_wb_rd = 0; m_wb_data = 0;
      m_cnt = 0; m_prev_det = 0;
    end else begin
      if ((h || s) && (m_cnt < (1 << CW) - 1)) m_cnt++;
      m_prev_det = s;
      if (h) begin
        m_wb_wr = 0; m_wb_rd = 0; m_wb_data = 0;
      end else begin
        m_wb_wr = m_mem_wr;
        m_wb_rd = m_mem_rd;
        if (m_mem_src == 2'b01)      m_wb_data = dm_rdata;
        else if (m_mem_src == 2'b10) m_wb_data = m_mem_pc4;
        else                         m_wb_data = m_mem_alu;
        m_mem_wr  = ex_valid && RUWrex && (rd_ex != 5'd0);
        m_mem_rd  = m_mem_wr ? rd_ex : 5'd0;
        m_mem_ld  = ex_valid && DMRdex;
        m_mem_src = RUDataWrSrcex;
        m_mem_alu = alu_ex;
        m_mem_pc4 = pc4_ex;
      end
    end
  endtask

  task automatic check_all();
    check("rd_mem",       32'(rd_mem),       32'(m_mem_rd));
    check("RUWrme",       32'(RUWrme),       32'(m_mem_wr));
    check("fwd_mem_data", fwd_mem_data,      (m_mem_src == 2'b10) ? m_mem_pc4 : m_mem_alu);
    check("rd_wb",        32'(rd_wb),        32'(m_wb_rd));
    check("RUWrwb",       32'(RUWrwb),       32'(m_wb_wr));
    check("fwd_wb_data",  fwd_wb_data,       m_wb_data);
    check("stall_fd",     32'(stall_fd),     32'(exp_stall()));
    check("bubble_ex",    32'(bubble_ex),    32'(exp_stall()));
    check("hold_all",     32'(hold_all),     32'(exp_hold()));
    check("stall_cnt",    32'(stall_cnt),    32'(m_cnt));
  endtask

  // Inputs are already driven; check on the falling edge, advance on rising.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; rd_ex = 0; RUWrex = 0; DMRdex = 0; RUDataWrSrcex = 2'b00;
    alu_ex = 0; pc4_ex = 0; rs1_id = 0; rs2_id = 0;
    rs1_use_id = 0; rs2_use_id = 0; dm_ready = 1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic [1:0] src,
                        input logic [XL-1:0] alu);
    ex_valid = v; rd_ex = rd; RUWrex = wr; DMRdex = ld;
    RUDataWrSrcex = src; alu_ex = alu; pc4_ex = alu + 32'd4;
  endtask

  initial begin
    // Reset: DUT state is unknown until the first edge, so no checks yet.
    rst = 1;
    idle_inputs();
    repeat (2) begin
      @(posedge clk);
      model_update();
      #1;
    end
    tick();
    rst = 0;

    // Idle after reset
    #2;
    check("rst_rd_mem",    32'(rd_mem),    32'd0);
    check("rst_rd_wb",     32'(rd_wb),     32'd0);
    check("rst_hold",      32'(hold_all),  32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (3) tick();
    check("idle_rd_wb",    32'(rd_wb),     32'd0);

    // ALU result to x5
    set_ex(1, 5'd5, 1, 0, 2'b00, 32'h10);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    #2;
    check("alu_rd_mem",   32'(rd_mem), 32'd5);
    check("alu_RUWrme",   32'(RUWrme), 32'd1);
    check("alu_fwd_mem",  fwd_mem_data, 32'h10);
    tick();
    #2;
    check("alu_rd_wb",    32'(rd_wb), 32'd5);
    check("alu_fwd_wb",   fwd_wb_data, 32'h10);

    // Write to x0, then a non-writing instruction naming x7
    set_ex(1, 5'd0, 1, 0, 2'b00, 32'h55);
    tick();
    set_ex(1, 5'd7, 0, 0, 2'b00, 32'h77);
    #2;
    check("x0_rd_mem", 32'(rd_mem), 32'd0);
    check("x0_RUWrme", 32'(RUWrme), 32'd0);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    #2;
    check("nowr_rd_mem", 32'(rd_mem), 32'd0);
    check("nowr_RUWrme", 32'(RUWrme), 32'd0);
    tick();

    // Load-use on rs2, memory ready
    dm_rdata = 32'hAB;
    set_ex(1, 5'd3, 1, 1, 2'b01, 32'h100);
    rs2_id = 5'd3; rs2_use_id = 1;
    #2;
    check("lu_stall_fd",  32'(stall_fd),  32'd1);
    check("lu_bubble_ex", 32'(bubble_ex), 32'd1);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    #2;
    check("lu_stall_1cyc",  32'(stall_fd),  32'd0);
    check("lu_bubble_1cyc", 32'(bubble_ex), 32'd0);
    tick();
    rs2_use_id = 0;
    #2;
    check("lu_rd_wb",     32'(rd_wb),     32'd3);
    check("lu_fwd_wb",    fwd_wb_data,    32'hAB);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Load waiting three cycles in MEM
    dm_rdata = 32'hCD;
    set_ex(1, 5'd4, 1, 1, 2'b01, 32'h200);
    tick();
    set_ex(1, 5'd6, 1, 0, 2'b00, 32'h66);
    dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("wt_hold", 32'(hold_all), 32'd1);
      if (i > 0) check("wt_RUWrwb", 32'(RUWrwb), 32'd0);
      tick();
    end
    dm_ready = 1;
    #2;
    check("wt_release", 32'(hold_all), 32'd0);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    #2;
    check("wt_rd_wb",     32'(rd_wb),     32'd4);
    check("wt_fwd_wb",    fwd_wb_data,    32'hCD);
    check("wt_rd_mem",    32'(rd_mem),    32'd6);
    check("wt_stall_cnt", 32'(stall_cnt), 32'd4);
    tick();
    #2;
    check("wt_once_rd_wb", 32'(rd_wb), 32'd6);
    tick();

    // Reset while waiting
    set_ex(1, 5'd2, 1, 1, 2'b01, 32'h300);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    dm_ready = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    dm_ready = 1;
    #2;
    check("rw_rd_mem",    32'(rd_mem),    32'd0);
    check("rw_RUWrwb",    32'(RUWrwb),    32'd0);
    check("rw_hold",      32'(hold_all),  32'd0);
    check("rw_stall_cnt", 32'(stall_cnt), 32'd0);
    set_ex(1, 5'd9, 1, 0, 2'b00, 32'h99);
    tick();
    set_ex(0, 5'd0, 0, 0, 2'b00, 32'h0);
    #2;
    check("rw_resume_rd_mem", 32'(rd_mem), 32'd9);
    check("rw_resume_fwd",    fwd_mem_data, 32'h99);
    tick();
    #2;
    check("rw_resume_rd_wb",  32'(rd_wb), 32'd9);
    tick();

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      ex_valid      = ($urandom_range(0, 7) != 0);
      rd_ex         = 5'($urandom_range(0, 7));
      RUWrex        = ($urandom_range(0, 3) != 0);
      DMRdex        = ($urandom_range(0, 2) == 0);
      RUDataWrSrcex = 2'($urandom_range(0, 3));
      alu_ex        = $urandom();
      pc4_ex        = $urandom();
      rs1_id        = 5'($urandom_range(0, 7));
      rs2_id        = 5'($urandom_range(0, 7));
      rs1_use_id    = ($urandom_range(0, 1) == 0);
      rs2_use_id    = ($urandom_range(0, 1) == 0);
      dm_rdata      = $urandom();
      dm_ready      = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fwd_source_pipe
`default_nettype wire
